// File: rtl/spatial_sram_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// spatial_sram_scheduler_pkg : shared encodings for the spatial SRAM scheduler
// Revision : 1.0
// ============================================================================
package spatial_sram_scheduler_pkg;

    localparam int NUM_MOD = 3;

    localparam logic [1:0] SEL_IM  = 2'd0;
    localparam logic [1:0] SEL_NEG = 2'd1;
    localparam logic [1:0] SEL_POS = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE_IM  = 3'd1,
        ST_ISSUE_NEG = 3'd2,
        ST_ISSUE_POS = 3'd3,
        ST_DRAIN     = 3'd4
    } fsm_state_e;

    typedef enum logic [1:0] {
        SLOT_EMPTY    = 2'd0,
        SLOT_FETCHING = 2'd1,
        SLOT_FULL     = 2'd2
    } slot_state_e;

    function automatic logic [1:0] onehot3_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spatial_sram_scheduler_rr_arbiter3.sv
`default_nettype none
// ============================================================================
// rr_arbiter3 : three-way round-robin arbiter, priority starts after last grant
// Revision : 1.0
// ============================================================================
module rr_arbiter3 (
    input  logic       Clk_CI,
    input  logic       Reset_RBI,
    input  logic [2:0] Req_SI,
    input  logic       Advance_SI,
    output logic [2:0] Grant_SO
);

    logic [2:0] last_q, last_d;

    always_comb begin
        Grant_SO = 3'b000;
        case (last_q)
            3'b001: begin
                if      (Req_SI[1]) Grant_SO = 3'b010;
                else if (Req_SI[2]) Grant_SO = 3'b100;
                else if (Req_SI[0]) Grant_SO = 3'b001;
            end
            3'b010: begin
                if      (Req_SI[2]) Grant_SO = 3'b100;
                else if (Req_SI[0]) Grant_SO = 3'b001;
                else if (Req_SI[1]) Grant_SO = 3'b010;
            end
            default: begin
                if      (Req_SI[0]) Grant_SO = 3'b001;
                else if (Req_SI[1]) Grant_SO = 3'b010;
                else if (Req_SI[2]) Grant_SO = 3'b100;
            end
        endcase
        last_d = last_q;
        if (Advance_SI && (|Grant_SO)) last_d = Grant_SO;
    end

    // Reset as "mod3 granted last" so mod1 wins the first arbitration.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) last_q <= 3'b100;
        else            last_q <= last_d;
    end

endmodule
`default_nettype wire

// File: rtl/spatial_sram_scheduler.sv
`default_nettype none
// ============================================================================
// spatial_sram_scheduler : shares one SRAM read port between three encoder modalities
// Revision : 1.0
// ============================================================================
module spatial_sram_scheduler
    import spatial_sram_scheduler_pkg::*;
#(
    parameter int HV_DIMENSION   = 2000,
    parameter int ROW_ADDR_WIDTH = 8
) (
    input  logic                        Clk_CI,
    input  logic                        Reset_RBI,
    input  logic                        Req_mod1_SI,
    input  logic                        Req_mod2_SI,
    input  logic                        Req_mod3_SI,
    input  logic [ROW_ADDR_WIDTH-1:0]   Addr_mod1_DI,
    input  logic [ROW_ADDR_WIDTH-1:0]   Addr_mod2_DI,
    input  logic [ROW_ADDR_WIDTH-1:0]   Addr_mod3_DI,
    input  logic                        Consume_mod1_SI,
    input  logic                        Consume_mod2_SI,
    input  logic                        Consume_mod3_SI,
    output logic                        Valid_mod1_SO,
    output logic                        Valid_mod2_SO,
    output logic                        Valid_mod3_SO,
    output logic [HV_DIMENSION-1:0]     IM_mod1_DO,
    output logic [HV_DIMENSION-1:0]     IM_mod2_DO,
    output logic [HV_DIMENSION-1:0]     IM_mod3_DO,
    output logic [HV_DIMENSION-1:0]     ProjNeg_mod1_DO,
    output logic [HV_DIMENSION-1:0]     ProjNeg_mod2_DO,
    output logic [HV_DIMENSION-1:0]     ProjNeg_mod3_DO,
    output logic [HV_DIMENSION-1:0]     ProjPos_mod1_DO,
    output logic [HV_DIMENSION-1:0]     ProjPos_mod2_DO,
    output logic [HV_DIMENSION-1:0]     ProjPos_mod3_DO,
    output logic                        SramReq_SO,
    output logic [ROW_ADDR_WIDTH+1:0]   SramAddr_DO,
    input  logic                        SramReady_SI,
    input  logic [HV_DIMENSION-1:0]     SramRdata_DI
);

    fsm_state_e                 state_q, state_d;
    slot_state_e                slot_q [NUM_MOD];
    slot_state_e                slot_d [NUM_MOD];
    logic [HV_DIMENSION-1:0]    im_q   [NUM_MOD];
    logic [HV_DIMENSION-1:0]    neg_q  [NUM_MOD];
    logic [HV_DIMENSION-1:0]    pos_q  [NUM_MOD];
    logic [ROW_ADDR_WIDTH-1:0]  row_q, row_d;
    logic [1:0]                 mod_q, mod_d;
    logic                       pend_vld_q, pend_vld_d;
    logic [1:0]                 pend_sel_q, pend_sel_d;

    logic [2:0]                 req_w, consume_w, elig_w, grant_w;
    logic [ROW_ADDR_WIDTH-1:0]  gaddr_w;
    logic [1:0]                 sel_w;
    logic                       arb_adv_w;

    assign req_w     = {Req_mod3_SI, Req_mod2_SI, Req_mod1_SI};
    assign consume_w = {Consume_mod3_SI, Consume_mod2_SI, Consume_mod1_SI};
    assign arb_adv_w = (state_q == ST_IDLE);

    always_comb begin
        elig_w = 3'b000;
        for (int m = 0; m < NUM_MOD; m++) begin
            elig_w[m] = req_w[m] && (slot_q[m] == SLOT_EMPTY);
        end
    end

    rr_arbiter3 u_arb (
        .Clk_CI     (Clk_CI),
        .Reset_RBI  (Reset_RBI),
        .Req_SI     (elig_w),
        .Advance_SI (arb_adv_w),
        .Grant_SO   (grant_w)
    );

    always_comb begin
        gaddr_w = Addr_mod1_DI;
        if      (grant_w[1]) gaddr_w = Addr_mod2_DI;
        else if (grant_w[2]) gaddr_w = Addr_mod3_DI;
    end

    // Fetch sequencer: one granted modality, three row reads, one drain cycle.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        mod_d      = mod_q;
        SramReq_SO = 1'b0;
        sel_w      = SEL_IM;
        case (state_q)
            ST_IDLE: begin
                if (|grant_w) begin
                    state_d = ST_ISSUE_IM;
                    row_d   = gaddr_w;
                    mod_d   = onehot3_to_idx(grant_w);
                end
            end
            ST_ISSUE_IM: begin
                SramReq_SO = 1'b1;
                sel_w      = SEL_IM;
                if (SramReady_SI) state_d = ST_ISSUE_NEG;
            end
            ST_ISSUE_NEG: begin
                SramReq_SO = 1'b1;
                sel_w      = SEL_NEG;
                if (SramReady_SI) state_d = ST_ISSUE_POS;
            end
            ST_ISSUE_POS: begin
                SramReq_SO = 1'b1;
                sel_w      = SEL_POS;
                if (SramReady_SI) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        SramAddr_DO = SramReq_SO ? {sel_w, row_q} : '0;
        pend_vld_d  = SramReq_SO && SramReady_SI;
        pend_sel_d  = sel_w;
    end

    always_comb begin
        for (int m = 0; m < NUM_MOD; m++) begin
            slot_d[m] = slot_q[m];
            case (slot_q[m])
                SLOT_EMPTY:
                    if (arb_adv_w && grant_w[m]) slot_d[m] = SLOT_FETCHING;
                SLOT_FETCHING:
                    if (pend_vld_q && (pend_sel_q == SEL_POS) && (mod_q == 2'(m)))
                        slot_d[m] = SLOT_FULL;
                SLOT_FULL:
                    if (consume_w[m]) slot_d[m] = SLOT_EMPTY;
                default: slot_d[m] = SLOT_EMPTY;
            endcase
        end
    end

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            mod_q      <= 2'd0;
            pend_vld_q <= 1'b0;
            pend_sel_q <= SEL_IM;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            mod_q      <= mod_d;
            pend_vld_q <= pend_vld_d;
            pend_sel_q <= pend_sel_d;
        end
    end

    // Read data lands one cycle after acceptance; the pending tag steers it.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            for (int m = 0; m < NUM_MOD; m++) begin
                slot_q[m] <= SLOT_EMPTY;
                im_q[m]   <= '0;
                neg_q[m]  <= '0;
                pos_q[m]  <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_MOD; m++) begin
                slot_q[m] <= slot_d[m];
                if (pend_vld_q && (mod_q == 2'(m))) begin
                    case (pend_sel_q)
                        SEL_IM:  im_q[m]  <= SramRdata_DI;
                        SEL_NEG: neg_q[m] <= SramRdata_DI;
                        SEL_POS: pos_q[m] <= SramRdata_DI;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign Valid_mod1_SO   = (slot_q[0] == SLOT_FULL);
    assign Valid_mod2_SO   = (slot_q[1] == SLOT_FULL);
    assign Valid_mod3_SO   = (slot_q[2] == SLOT_FULL);
    assign IM_mod1_DO      = im_q[0];
    assign IM_mod2_DO      = im_q[1];
    assign IM_mod3_DO      = im_q[2];
    assign ProjNeg_mod1_DO = neg_q[0];
    assign ProjNeg_mod2_DO = neg_q[1];
    assign ProjNeg_mod3_DO = neg_q[2];
    assign ProjPos_mod1_DO = pos_q[0];
    assign ProjPos_mod2_DO = pos_q[1];
    assign ProjPos_mod3_DO = pos_q[2];

endmodule
`default_nettype wire

// File: tb/tb_spatial_sram_scheduler.sv
`default_nettype none
// ============================================================================
// tb_spatial_sram_scheduler : directed scoreboard bench for spatial_sram_scheduler
// Revision : 1.0
// ============================================================================
module tb_spatial_sram_scheduler;

    localparam int HV = 32;
    localparam int RW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          req1, req2, req3, con1, con2, con3;
    logic [RW-1:0] addr1, addr2, addr3;
    logic          v1, v2, v3;
    logic [HV-1:0] im1, im2, im3, ng1, ng2, ng3, ps1, ps2, ps3;
    logic          sram_req, sram_rdy;
    logic [RW+1:0] sram_addr;
    logic [HV-1:0] sram_rdata;

    spatial_sram_scheduler #(.HV_DIMENSION(HV), .ROW_ADDR_WIDTH(RW)) dut (
        .Clk_CI(clk), .Reset_RBI(rst_n),
        .Req_mod1_SI(req1), .Req_mod2_SI(req2), .Req_mod3_SI(req3),
        .Addr_mod1_DI(addr1), .Addr_mod2_DI(addr2), .Addr_mod3_DI(addr3),
        .Consume_mod1_SI(con1), .Consume_mod2_SI(con2), .Consume_mod3_SI(con3),
        .Valid_mod1_SO(v1), .Valid_mod2_SO(v2), .Valid_mod3_SO(v3),
        .IM_mod1_DO(im1), .IM_mod2_DO(im2), .IM_mod3_DO(im3),
        .ProjNeg_mod1_DO(ng1), .ProjNeg_mod2_DO(ng2), .ProjNeg_mod3_DO(ng3),
        .ProjPos_mod1_DO(ps1), .ProjPos_mod2_DO(ps2), .ProjPos_mod3_DO(ps3),
        .SramReq_SO(sram_req), .SramAddr_DO(sram_addr),
        .SramReady_SI(sram_rdy), .SramRdata_DI(sram_rdata)
    );

    typedef struct {
        int            m;
        logic [HV-1:0] im;
        logic [HV-1:0] neg;
        logic [HV-1:0] pos;
    } exp_t;

    exp_t          exp_data[$];
    logic [RW+1:0] exp_addr[$];
    int            checks = 0;
    int            errors = 0;

    function automatic logic [HV-1:0] row_model(input logic [RW+1:0] a);
        return (32'h9E37_79B9 * (32'(a) + 32'd1)) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic valid_of(input int m);
        return (m == 1) ? v1 : (m == 2) ? v2 : v3;
    endfunction

    task automatic get_slot(input int m, output logic [HV-1:0] im, output logic [HV-1:0] ng,
                            output logic [HV-1:0] ps);
        case (m)
            1:       begin im = im1; ng = ng1; ps = ps1; end
            2:       begin im = im2; ng = ng2; ps = ps2; end
            default: begin im = im3; ng = ng3; ps = ps3; end
        endcase
    endtask

    task automatic push_fetch(input int m, input logic [RW-1:0] row);
        exp_t e;
        exp_addr.push_back({2'd0, row});
        exp_addr.push_back({2'd1, row});
        exp_addr.push_back({2'd2, row});
        e.m   = m;
        e.im  = row_model({2'd0, row});
        e.neg = row_model({2'd1, row});
        e.pos = row_model({2'd2, row});
        exp_data.push_back(e);
    endtask

    task automatic check_slot(input int m);
        exp_t          e;
        logic [HV-1:0] im, ng, ps;
        if (exp_data.size() == 0) begin
            chk("sb_underflow", 64'(exp_data.size()), 64'd1);
        end else begin
            e = exp_data.pop_front();
            get_slot(m, im, ng, ps);
            chk("slot_modality", 64'(m), 64'(e.m));
            chk("slot_im", im, e.im);
            chk("slot_neg", ng, e.neg);
            chk("slot_pos", ps, e.pos);
        end
    endtask

    task automatic wait_valid(input int m, output int lat);
        lat = 0;
        while (!valid_of(m) && lat < 64) begin
            tick();
            lat++;
        end
        chk("valid_timeout", valid_of(m), 1'b1);
    endtask

    task automatic wait_any(output int m);
        int n;
        n = 0;
        while (!(v1 || v2 || v3) && n < 64) begin
            tick();
            n++;
        end
        m = v1 ? 1 : v2 ? 2 : v3 ? 3 : 0;
        chk("any_valid_timeout", 64'(v1 || v2 || v3), 64'd1);
    endtask

    task automatic consume(input int m);
        con1 = (m == 1);
        con2 = (m == 2);
        con3 = (m == 3);
        tick();
        con1 = 1'b0;
        con2 = 1'b0;
        con3 = 1'b0;
    endtask

    always @(posedge clk) begin
        if (sram_req && sram_rdy) sram_rdata <= row_model(sram_addr);
        else                      sram_rdata <= HV'($urandom);
    end

    always @(negedge clk) begin
        if (rst_n && sram_req && sram_rdy) begin
            if (exp_addr.size() == 0) chk("sram_unexpected_req", 64'(exp_addr.size()), 64'd1);
            else                      chk("sram_addr_seq", sram_addr, exp_addr.pop_front());
        end
    end

    initial begin
        int lat;
        int m;
        int order[4];
        logic [HV-1:0] im, ng, ps;
        order = '{1, 2, 3, 1};

        rst_n = 1'b0; req1 = 0; req2 = 0; req3 = 0; con1 = 0; con2 = 0; con3 = 0;
        addr1 = '0; addr2 = '0; addr3 = '0; sram_rdy = 1'b1;
        #1;
        chk("rst_valid", {v1, v2, v3}, 3'b000);
        chk("rst_sram_req", sram_req, 1'b0);
        chk("rst_sram_addr", sram_addr, '0);
        chk("rst_data", {im1, ng2, ps3}, '0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single fetch, row 5
        req1 = 1'b1; addr1 = 8'd5; push_fetch(1, 8'd5);
        tick();
        req1 = 1'b0;
        wait_valid(1, lat);
        chk("lat_single", 64'(lat + 1), 64'd5);
        check_slot(1);
        consume(1);
        chk("valid1_after_consume", v1, 1'b0);

        // Round-robin from reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req1 = 1; req2 = 1; req3 = 1; addr1 = 8'd10; addr2 = 8'd20; addr3 = 8'd30;
        push_fetch(1, 8'd10); push_fetch(2, 8'd20); push_fetch(3, 8'd30); push_fetch(1, 8'd10);
        for (int k = 0; k < 4; k++) begin
            wait_any(m);
            chk("rr_order", 64'(m), 64'(order[k]));
            check_slot(m);
            if (k == 2) begin req2 = 0; req3 = 0; end
            if (k == 3) req1 = 0;
            consume(m);
        end

        // Stall three cycles in ISSUE_NEG
        req1 = 1'b1; addr1 = 8'd7; push_fetch(1, 8'd7);
        tick();
        req1 = 1'b0;
        tick();
        sram_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_req", sram_req, 1'b1);
            chk("stall_addr", sram_addr, {2'd1, 8'd7});
            tick();
        end
        sram_rdy = 1'b1;
        wait_valid(1, lat);
        chk("lat_stall", 64'(lat + 5), 64'd8);
        check_slot(1);
        consume(1);

        // Req and Addr dropped/changed mid-fetch
        req2 = 1'b1; addr2 = 8'd40; push_fetch(2, 8'd40);
        tick();
        req2 = 1'b0; addr2 = 8'd99;
        wait_valid(2, lat);
        chk("lat_drop", 64'(lat + 1), 64'd5);
        check_slot(2);
        tick(); tick(); tick();
        chk("valid2_held", v2, 1'b1);
        get_slot(2, im, ng, ps);
        chk("held_im2", im, row_model({2'd0, 8'd40}));
        consume(2);
        chk("valid2_after_consume", v2, 1'b0);

        // Consume in the same cycle as a new request
        req3 = 1'b1; addr3 = 8'd50; push_fetch(3, 8'd50);
        tick();
        req3 = 1'b0;
        wait_valid(3, lat);
        check_slot(3);
        con3 = 1'b1; req3 = 1'b1; addr3 = 8'd60; push_fetch(3, 8'd60);
        tick();
        con3 = 1'b0;
        chk("no_grant_in_consume_cycle", sram_req, 1'b0);
        chk("valid3_dropped", v3, 1'b0);
        tick();
        chk("grant_next_req", sram_req, 1'b1);
        chk("grant_next_addr", sram_addr, {2'd0, 8'd60});
        req3 = 1'b0;
        wait_valid(3, lat);
        chk("lat_after_consume", 64'(lat), 64'd4);
        check_slot(3);
        consume(3);

        // Async reset during ISSUE_POS
        req1 = 1'b1; addr1 = 8'd3; push_fetch(1, 8'd3);
        tick(); tick(); tick();
        req1 = 1'b0;
        chk("pre_reset_pos_addr", sram_addr, {2'd2, 8'd3});
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {v1, v2, v3}, 3'b000);
        chk("async_rst_req", sram_req, 1'b0);
        chk("async_rst_addr", sram_addr, '0);
        chk("async_rst_data", {im1, ng1, ps1, im2, ng2, ps2, im3, ng3, ps3}, '0);
        exp_addr.delete();
        exp_data.delete();
        tick();
        rst_n = 1'b1;
        tick();
        req3 = 1'b1; addr3 = 8'd77; push_fetch(3, 8'd77);
        tick();
        req3 = 1'b0;
        wait_valid(3, lat);
        chk("lat_post_reset", 64'(lat + 1), 64'd5);
        check_slot(3);
        consume(3);
        tick();

        chk("addr_queue_drained", 64'(exp_addr.size()), 64'd0);
        chk("sb_drained", 64'(exp_data.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spatial_sram_scheduler.md
Name: spatial_sram_scheduler

Overview:
- Shares one single-port, 1-cycle-latency SRAM read port between the three spatial-encoder modalities.
- Each SRAM row holds one matrix row: iM, projM_neg or projM_pos.
- Per modality request, the block fetches the three rows for the requested channel and parks them in a per-modality holding slot.
- It raises that modality's valid until the encoder consumes the data. It sits between the SRAM macro and the spatial encoder's IM/projM/valid inputs.

Parameters:
- HV_DIMENSION, 2000, hypervector/row width in bits
- ROW_ADDR_WIDTH, 8, channel-row address width (covers 214 channels)

Ports:
- Clk_CI  in  1  clock
- Reset_RBI  in  1  reset, asynchronous, active-low
- Req_mod1_SI / Req_mod2_SI / Req_mod3_SI  in  1 each  modality needs rows at its address
- Addr_mod1_DI / Addr_mod2_DI / Addr_mod3_DI  in  ROW_ADDR_WIDTH each  channel row address
- Consume_mod1_SI / Consume_mod2_SI / Consume_mod3_SI  in  1 each  encoder used the slot contents
- Valid_mod1_SO / Valid_mod2_SO / Valid_mod3_SO  out  1 each  slot FULL
- IM_modN_DO, ProjNeg_modN_DO, ProjPos_modN_DO (N=1..3)  out  HV_DIMENSION each  slot contents
- SramReq_SO  out  1  read request
- SramAddr_DO  out  2+ROW_ADDR_WIDTH  {matrix_sel, row}; sel 0=iM, 1=projM_neg, 2=projM_pos
- SramReady_SI  in  1  macro accepts request this cycle
- SramRdata_DI  in  HV_DIMENSION  read data, valid exactly 1 cycle after an accepted request

Behaviour:
- Reset (async, Reset_RBI=0): all slots EMPTY, all Valid_*=0, all data outputs 0, SramReq_SO=0, SramAddr_DO=0, FSM IDLE, round-robin pointer set so mod1 has highest priority.
- Slot state per modality: EMPTY -> FETCHING -> FULL -> EMPTY.
  - Valid_modN_SO = (slot FULL), driven from a register.
- Eligibility: modality eligible when Req=1 and its slot is EMPTY, evaluated on registered state.
- Arbitration (FSM IDLE only): round-robin among eligible modalities, starting after the last granted one.
  - Grant latches Addr and modality id; slot goes to FETCHING.
- FSM states and transitions:
  - IDLE -> ISSUE_IM on any grant.
  - ISSUE_IM -> ISSUE_NEG -> ISSUE_POS -> DRAIN.
  - Each ISSUE_* state drives SramReq_SO=1 with sel 0/1/2 and the latched row, and advances only when SramReady_SI=1.
  - DRAIN -> IDLE unconditionally.
- Capture: a registered "pending" tag (valid + sel) is set on each accepted request. The next cycle, SramRdata_DI is written to the matching IM/ProjNeg/ProjPos register of the granted modality.
  - The pos capture in DRAIN sets the slot FULL.
  - Stalls never lose or misplace data.
- Latency: with SramReady_SI held at 1, grant cycle to Valid=1 is 5 cycles (grant, 3 issues, capture), i.e. 4 cycles after the first request is issued.
- Consume_modN_SI while FULL: slot EMPTY next cycle and Valid drops. Consume while EMPTY or FETCHING is ignored.
- Same-cycle Consume and eligibility: that modality is not eligible in the Consume cycle; it can be granted from the next cycle.
- Req dropped during FETCHING: the fetch completes and the slot becomes FULL. Data is held until Consume.
- Addr change while FETCHING or FULL: ignored. The slot keeps the latched row.
- Data outputs hold their last captured values when a slot is EMPTY.
- Throughput: one fetch in flight at a time; no prefetch.

Decomposition:
- Shared package/const header: matrix_sel encodings (SEL_IM=0, SEL_NEG=1, SEL_POS=2), FSM state encodings, and slot state encodings.
- Sub-module rr_arbiter3: 3 requests, registered last-grant pointer, one-hot grant, advance enable.
- Holding registers and FSM stay in the top module.

Test Plan:
- Single fetch: Req_mod1=1, Addr=5, SramReady=1 -> SramAddr sequence {0,5},{1,5},{2,5}; IM/Neg/Pos_mod1 equal the model rows; Valid_mod1=1 at grant+5; Consume -> Valid_mod1=0 next cycle.
- Round-robin: all three Req=1 from reset, each consumed immediately -> grant order 1,2,3,1; no modality granted twice before the others.
- Stall: SramReady=0 for 3 cycles in ISSUE_NEG -> SramAddr held at {1,row}; captured rows still correct; Valid delayed by exactly 3 cycles.
- Req dropped mid-fetch: Req_mod2 deasserted after grant -> slot still fills, Valid_mod2=1 and held until Consume_mod2.
- Consume in same cycle as a new Req: no grant that cycle; grant the next cycle; the new Addr is fetched.
- Async reset asserted during ISSUE_POS: all Valid, SramReq, SramAddr and data go 0 immediately. After release, a fresh Req_mod3 fetch completes correctly.
